// File: rtl/blk_pkg.sv
// Shared definitions for the block emitter: command and state encodings,
// ASCII constants and the letter count of each command's keyword.
package blk_pkg;

  typedef enum logic [1:0] {
    CMD_BEGIN = 2'b00,
    CMD_END   = 2'b01,
    CMD_WORD  = 2'b10,
    CMD_SPACE = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EMIT = 2'b01,
    ST_SEP  = 2'b10
  } state_e;

  localparam int         IDX_W       = 3;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] CASE_OFFSET = 8'h20;

  localparam logic [IDX_W-1:0] LEN_BEGIN = 3'd5;
  localparam logic [IDX_W-1:0] LEN_END   = 3'd3;
  localparam logic [IDX_W-1:0] LEN_WORD  = 3'd1;

  // SPACE has no letters; it never enters EMIT, so its length is never used.
  function automatic logic [IDX_W-1:0] cmd_len(input cmd_e c);
    case (c)
      CMD_BEGIN: cmd_len = LEN_BEGIN;
      CMD_END:   cmd_len = LEN_END;
      CMD_WORD:  cmd_len = LEN_WORD;
      default:   cmd_len = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/blk_char_rom.sv
// Letter lookup for the block emitter.
// Ports:
//   cmd_i   : command whose keyword is being spelled
//   idx_i   : letter index within the keyword
//   upper_i : 1 = upper-case output
//   char_o  : ASCII letter, 0x00 for an out-of-range index or SPACE
module blk_char_rom
  import blk_pkg::*;
(
  input  logic [1:0]       cmd_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             upper_i,
  output logic [7:0]       char_o
);

  logic [7:0] lower;

  always_comb begin
    lower = 8'h00;
    case (cmd_e'(cmd_i))
      CMD_BEGIN: begin
        case (idx_i)
          3'd0:    lower = 8'h62;
          3'd1:    lower = 8'h65;
          3'd2:    lower = 8'h67;
          3'd3:    lower = 8'h69;
          3'd4:    lower = 8'h6E;
          default: lower = 8'h00;
        endcase
      end
      CMD_END: begin
        case (idx_i)
          3'd0:    lower = 8'h65;
          3'd1:    lower = 8'h6E;
          3'd2:    lower = 8'h64;
          default: lower = 8'h00;
        endcase
      end
      CMD_WORD: begin
        if (idx_i == 3'd0) lower = 8'h78;
      end
      default: lower = 8'h00;
    endcase
  end

  // Only letters are shifted; the null code stays null.
  assign char_o = (upper_i && (lower != 8'h00)) ? (lower - CASE_OFFSET) : lower;

endmodule

// File: rtl/block_emitter.sv
// Block emitter: turns BEGIN/END/WORD/SPACE commands into an ASCII character
// stream ("begin ", "end ", "x ", " ") and tracks block nesting depth.
//
// state | meaning
// IDLE  | ready for a command, no character presented
// EMIT  | presenting letter idx_q of the latched command
// SEP   | presenting the trailing space
//
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   cmd_valid/cmd/cmd_upper/cmd_ready : command handshake
//   out_char/out_valid/out_ready      : character stream handshake
//   depth               : open-block count (saturating)
//   err                 : sticky underflow/overflow flag
//   balanced            : depth == 0 and no error
module block_emitter
  import blk_pkg::*;
#(
  parameter int DEPTH_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd,
  input  logic               cmd_upper,
  output logic               cmd_ready,
  output logic [7:0]         out_char,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DEPTH_W-1:0] depth,
  output logic               err,
  output logic               balanced
);

  state_e             state_q, state_d;
  cmd_e               cmd_q, cmd_d;
  logic               upper_q, upper_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               err_q, err_d;
  logic [7:0]         rom_char;
  logic               last_letter;

  // Characters come from registered command/index only, so there is no
  // combinational path from the command port to out_char.
  blk_char_rom u_rom (
    .cmd_i   (cmd_q),
    .idx_i   (idx_q),
    .upper_i (upper_q),
    .char_o  (rom_char)
  );

  assign last_letter = (idx_q == (cmd_len(cmd_q) - 3'd1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_BEGIN;
      upper_q <= 1'b0;
      idx_q   <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      upper_q <= upper_d;
      idx_q   <= idx_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    upper_d   = upper_q;
    idx_d     = idx_q;
    depth_d   = depth_q;
    err_d     = err_q;
    cmd_ready = 1'b0;
    out_valid = 1'b0;
    out_char  = 8'h00;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cmd_d   = cmd_e'(cmd);
          upper_d = cmd_upper;
          idx_d   = '0;
          state_d = (cmd_e'(cmd) == CMD_SPACE) ? ST_SEP : ST_EMIT;
          // Depth saturates at both ends; the command is still spelled out.
          case (cmd_e'(cmd))
            CMD_BEGIN: begin
              if (depth_q == '1) err_d = 1'b1;
              else               depth_d = depth_q + DEPTH_W'(1);
            end
            CMD_END: begin
              if (depth_q == '0) err_d = 1'b1;
              else               depth_d = depth_q - DEPTH_W'(1);
            end
            default: ;
          endcase
        end
      end

      ST_EMIT: begin
        out_valid = 1'b1;
        out_char  = rom_char;
        if (out_ready) begin
          if (last_letter) state_d = ST_SEP;
          else             idx_d   = idx_q + 3'd1;
        end
      end

      ST_SEP: begin
        out_valid = 1'b1;
        out_char  = ASCII_SPACE;
        if (out_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign depth    = depth_q;
  assign err      = err_q;
  assign balanced = (depth_q == '0) && !err_q;

endmodule

// File: tb/tb_block_emitter.sv
module tb_block_emitter;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic       cmd_upper;
  logic       cmd_ready;
  logic [7:0] out_char;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] depth;
  logic       err;
  logic       balanced;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  int         mdl_depth;
  logic       mdl_err;

  block_emitter #(.DEPTH_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_upper (cmd_upper),
    .cmd_ready (cmd_ready),
    .out_char  (out_char),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .depth     (depth),
    .err       (err),
    .balanced  (balanced)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic string keyword(input logic [1:0] c, input logic up);
    case (c)
      2'b00:   return up ? "BEGIN" : "begin";
      2'b01:   return up ? "END" : "end";
      2'b10:   return up ? "X" : "x";
      default: return "";
    endcase
  endfunction

  // Offer one command starting at a falling edge; it is accepted at the next
  // rising edge. Returns at the following falling edge.
  task automatic issue(input logic [1:0] c, input logic up);
    string s;
    chk("cmd_ready_before_issue", cmd_ready, 1);
    s = keyword(c, up);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h20);
    if (c == 2'b00) begin
      if (mdl_depth == 255) mdl_err = 1'b1;
      else                  mdl_depth++;
    end else if (c == 2'b01) begin
      if (mdl_depth == 0) mdl_err = 1'b1;
      else                mdl_depth--;
    end
    cmd_valid = 1'b1;
    cmd       = c;
    cmd_upper = up;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd       = 2'b00;
    cmd_upper = 1'b0;
  endtask

  // Consume every expected character with out_ready held high: one per cycle.
  task automatic drain();
    logic [7:0] e;
    int n;
    out_ready = 1'b1;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      chk("out_valid", out_valid, 1);
      chk("out_char", out_char, e);
      @(negedge clk);
    end
    chk("cmd_ready_after", cmd_ready, 1);
    chk("out_valid_idle", out_valid, 0);
    chk("out_char_idle", out_char, 8'h00);
    chk("depth", depth, mdl_depth);
    chk("err", err, mdl_err);
    chk("balanced", balanced, (mdl_depth == 0) && !mdl_err);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    exp_q.delete();
    mdl_depth = 0;
    mdl_err   = 1'b0;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_char", out_char, 8'h00);
    chk("rst_depth", depth, 0);
    chk("rst_err", err, 0);
    chk("rst_balanced", balanced, 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] e;
    cmd_valid = 1'b0;
    cmd       = 2'b00;
    cmd_upper = 1'b0;
    out_ready = 1'b1;
    mdl_depth = 0;
    mdl_err   = 1'b0;
    do_reset();

    // BEGIN lower-case
    issue(2'b00, 1'b0);
    drain();
    // END upper-case closes it
    issue(2'b01, 1'b1);
    drain();

    // WORD with three stalled cycles
    out_ready = 1'b0;
    issue(2'b10, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_char", out_char, 8'h78);
      chk("stall_cmd_ready", cmd_ready, 0);
      if (i == 3) out_ready = 1'b1;
      @(negedge clk);
    end
    e = exp_q.pop_front();
    chk("stall_popped", e, 8'h78);
    chk("sep_cmd_ready", cmd_ready, 0);
    drain();

    // SPACE alone, upper flag irrelevant
    issue(2'b11, 1'b1);
    drain();

    // END at depth 0: underflow, string still emitted
    issue(2'b01, 1'b0);
    drain();
    issue(2'b00, 1'b1);
    drain();
    issue(2'b01, 1'b0);
    drain();
    chk("err_sticky", err, 1);

    // Reset after two letters of BEGIN
    issue(2'b00, 1'b0);
    chk("mid_char0", out_char, 8'h62);
    @(negedge clk);
    chk("mid_char1", out_char, 8'h65);
    @(negedge clk);
    reset = 1'b1;
    #1;
    exp_q.delete();
    mdl_depth = 0;
    mdl_err   = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_char", out_char, 8'h00);
    chk("abort_depth", depth, 0);
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_err", err, 0);
    @(negedge clk);
    chk("held_valid", out_valid, 0);
    reset = 1'b0;
    @(negedge clk);
    issue(2'b10, 1'b1);
    drain();

    // Saturation at 255
    do_reset();
    for (int k = 0; k < 255; k++) begin
      issue(2'b00, 1'b0);
      drain();
    end
    chk("sat_depth", depth, 255);
    chk("sat_err", err, 0);
    issue(2'b00, 1'b0);
    drain();
    chk("ovf_depth", depth, 255);
    chk("ovf_err", err, 1);
    chk("ovf_balanced", balanced, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
